// File: rtl/uart_sched_pkg.sv
// ---------------------------------------------------------------------------
// uart_sched_pkg
// Shared types and constants for the UART transmit scheduler.
//   schedState_t : scheduler FSM states
//   HDR_TAG      : upper nibble of the optional per-message header byte
//   idxWidth()   : bits needed to index n items (never less than 1)
// No ports (package).
// ---------------------------------------------------------------------------
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } schedState_t;

  localparam logic [3:0] HDR_TAG = 4'hA;

  // Index width helper: $clog2 collapses to 0 for n<=1, which would give
  // zero-width vectors, so one bit is the floor.
  function automatic int idxWidth(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The winner is the first requester found
// searching upward, with wrap, starting one above the previous winner.
// Ports:
//   req        in  [N-1:0]  level requests
//   last_grant in  [W-1:0]  index of the previous winner
//   grant      out [N-1:0]  one-hot winner, all zero when req is zero
// ---------------------------------------------------------------------------
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idxWidth(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic [N-1:0] grant
);

  int w_dist;
  int w_bestDist;
  int w_bestIdx;

  // Each requester gets a rotated distance from the slot just after the
  // previous winner; the closest active requester wins. Indexing only with
  // loop variables keeps every bit select statically sized.
  always_comb begin
    grant      = '0;
    w_dist     = 0;
    w_bestDist = N;
    w_bestIdx  = 0;
    for (int i = 0; i < N; i++) begin
      w_dist = i - int'(last_grant) - 1;
      if (w_dist < 0) begin
        w_dist = w_dist + N;
      end
      if (req[i] && (w_dist < w_bestDist)) begin
        w_bestDist = w_dist;
        w_bestIdx  = i;
      end
    end
    for (int i = 0; i < N; i++) begin
      grant[i] = (w_bestDist < N) && (w_bestIdx == i);
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
// Shares one uart_tx among N_REQ requesters. A round-robin winner's whole
// message is latched, then fed byte by byte (byte 0 first) through the
// start_tx / tx_busy handshake. Messages are never interleaved.
// Optional feature macro: UART_SCHED_HDR_EN -- when defined, each message is
// prefixed with header byte {HDR_TAG, winner id}.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous active-high reset
//   req         in   [N_REQ-1:0] level request per requester
//   req_data    in   [N_REQ*MSG_BYTES*8-1:0] flat payloads, requester i at
//                    slice [i*MSG_BYTES*8 +: MSG_BYTES*8]
//   ack         out  [N_REQ-1:0] one-hot pulse, payload latched
//   done        out  pulse, last byte finished on the line
//   err         out  pulse, tx_busy never rose, message dropped
//   busy        out  high from grant until done/err
//   data_to_tx  out  [7:0] byte to uart_tx
//   start_tx    out  registered start pulse to uart_tx
//   tx_busy     in   busy flag from uart_tx
// ---------------------------------------------------------------------------
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int MSG_BYTES   = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*MSG_BYTES*8-1:0] req_data,
  output logic [N_REQ-1:0]             ack,
  output logic                         done,
  output logic                         err,
  output logic                         busy,
  output logic [7:0]                   data_to_tx,
  output logic                         start_tx,
  input  logic                         tx_busy
);

`ifdef UART_SCHED_HDR_EN
  localparam int HDR_BYTES = 1;
`else
  localparam int HDR_BYTES = 0;
`endif

  localparam int TOTAL = MSG_BYTES + HDR_BYTES;
  localparam int PW    = MSG_BYTES * 8;
  localparam int BW    = TOTAL * 8;
  localparam int LG_W  = idxWidth(N_REQ);
  localparam int IDX_W = idxWidth(TOTAL);
  localparam int CNT_W = idxWidth(ACK_TIMEOUT);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [LG_W-1:0]  LG_RESET = LG_W'(N_REQ - 1);

  schedState_t      r_state;
  logic [LG_W-1:0]  r_lastGrant;
  logic [IDX_W-1:0] r_byteIdx;
  logic [CNT_W-1:0] r_ackCnt;
  logic [BW-1:0]    r_msgBuf;

  logic [N_REQ-1:0] w_grant;
  logic [LG_W-1:0]  w_winIdx;
  logic [PW-1:0]    w_payload;
  logic [BW-1:0]    w_newMsg;
  logic [7:0]       w_curByte;

  rr_arbiter #(
    .N (N_REQ),
    .W (LG_W)
  ) u_arb (
    .req        (req),
    .last_grant (r_lastGrant),
    .grant      (w_grant)
  );

  // Turn the one-hot grant into a binary winner id and pick out that
  // requester's payload slice, ready to be latched when IDLE arbitrates.
  always_comb begin
    w_winIdx  = '0;
    w_payload = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_winIdx  = LG_W'(i);
        w_payload = req_data[i*PW +: PW];
      end
    end
  end

  // The message buffer holds every byte that goes on the line, so the
  // header (when enabled) simply sits in byte slot 0 ahead of the payload.
`ifdef UART_SCHED_HDR_EN
  assign w_newMsg = {w_payload, HDR_TAG, 4'(w_winIdx)};
`else
  assign w_newMsg = w_payload;
`endif

  assign w_curByte = 8'(r_msgBuf >> {r_byteIdx, 3'b000});

  // Scheduler FSM with registered outputs. Pulses (ack, done, err,
  // start_tx) default low every cycle. data_to_tx is only loaded when a
  // byte is launched, so it stays put for the whole uart_tx transfer.
  // The timeout counter starts at launch and err lands ACK_TIMEOUT cycles
  // after the start_tx pulse if tx_busy never rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_lastGrant <= LG_RESET;
      r_byteIdx   <= '0;
      r_ackCnt    <= '0;
      r_msgBuf    <= '0;
      ack         <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
      data_to_tx  <= 8'h00;
      start_tx    <= 1'b0;
    end else begin
      ack      <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      start_tx <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_msgBuf    <= w_newMsg;
            ack         <= w_grant;
            r_lastGrant <= w_winIdx;
            r_byteIdx   <= '0;
            busy        <= 1'b1;
            r_state     <= START;
          end
        end
        START: begin
          if (!tx_busy) begin
            start_tx   <= 1'b1;
            data_to_tx <= w_curByte;
            r_ackCnt   <= '0;
            r_state    <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (tx_busy) begin
            r_state <= WAIT_LO;
          end else if (r_ackCnt == CNT_MAX) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_ackCnt <= r_ackCnt + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (r_byteIdx == LAST_IDX) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_byteIdx <= r_byteIdx + 1'b1;
              r_state   <= START;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
// Directed bench for uart_tx_sched (N_REQ=4, MSG_BYTES=2, ACK_TIMEOUT=15)
// with a small uart_tx stub that raises tx_busy for 4 cycles per start_tx.
// Header bytes are expected only when UART_SCHED_HDR_EN is defined.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  ack;
  logic        done;
  logic        err;
  logic        busy;
  logic [7:0]  data_to_tx;
  logic        start_tx;
  logic        tx_busy;

  logic        stubBusy;
  logic        forceBusy;
  logic        stubMute;
  int          stubCnt;
  logic [7:0]  txBytes[$];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  reqV;
    logic [63:0] dataV;
    logic [3:0]  expAck;
    int          expId;
    logic [15:0] expPay;
  } vec_t;

  vec_t vecs[6];

  uart_tx_sched #(
    .N_REQ       (4),
    .MSG_BYTES   (2),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .done       (done),
    .err        (err),
    .busy       (busy),
    .data_to_tx (data_to_tx),
    .start_tx   (start_tx),
    .tx_busy    (tx_busy)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  assign tx_busy = stubBusy | forceBusy;

  // Hard stop in case something upstream stalls outside a bounded wait.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [63:0] d);
    @(negedge clk);
    req      = r;
    req_data = d;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    req   = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    txBytes.delete();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".ack"},      64'(ack),        64'h0);
    checkOutput({tag, ".done"},     64'(done),       64'h0);
    checkOutput({tag, ".err"},      64'(err),        64'h0);
    checkOutput({tag, ".busy"},     64'(busy),       64'h0);
    checkOutput({tag, ".start_tx"}, 64'(start_tx),   64'h0);
    checkOutput({tag, ".data"},     64'(data_to_tx), 64'h0);
  endtask

  task automatic waitAck(output logic seen, output int lat);
    seen = 1'b0;
    lat  = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      lat++;
      if (|ack) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitDone(output logic seen, output int extraAcks);
    seen      = 1'b0;
    extraAcks = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (|ack) extraAcks++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic checkMsg(input string tag, input int id, input logic [15:0] pay);
    logic [7:0]  exp[$];
    logic [63:0] act;
`ifdef UART_SCHED_HDR_EN
    exp.push_back({4'hA, 4'(id)});
`endif
    exp.push_back(pay[7:0]);
    exp.push_back(pay[15:8]);
    checkOutput({tag, ".nbytes"}, 64'(txBytes.size()), 64'(exp.size()));
    foreach (exp[i]) begin
      act = (i < txBytes.size()) ? 64'(txBytes[i]) : 64'hDEAD;
      checkOutput($sformatf("%s.byte%0d", tag, i), act, 64'(exp[i]));
    end
  endtask

  // uart_tx stub and line monitor, evaluated on the falling edge so it
  // never races the DUT. Every launched byte is recorded and checked for
  // the rule that start_tx never fires while tx_busy is high.
  initial begin
    stubBusy = 1'b0;
    stubCnt  = 0;
    forever begin
      @(negedge clk);
      if (start_tx) begin
        checkOutput("noStartWhileBusy", 64'(tx_busy), 64'h0);
        txBytes.push_back(data_to_tx);
      end
      if (stubCnt > 0) begin
        stubCnt--;
        if (stubCnt == 0) stubBusy = 1'b0;
      end else if (start_tx && !stubMute) begin
        stubBusy = 1'b1;
        stubCnt  = 4;
      end
    end
  end

  // Main sequence: reset state, table of single messages, then the
  // multi-cycle corner cases.
  initial begin
    logic seen;
    int   lat;
    int   extra;
    int   n;
    logic [3:0] expAck;

    vecs[0] = '{4'b0001, {16'h1111, 16'h2222, 16'h3333, 16'hBEEF}, 4'b0001, 0, 16'hBEEF};
    vecs[1] = '{4'b0101, {16'h4444, 16'h1234, 16'h5555, 16'h6666}, 4'b0100, 2, 16'h1234};
    vecs[2] = '{4'b0011, {16'h7777, 16'h8888, 16'h9999, 16'hA55A}, 4'b0001, 0, 16'hA55A};
    vecs[3] = '{4'b1001, {16'hC3D2, 16'h1357, 16'h2468, 16'hFACE}, 4'b1000, 3, 16'hC3D2};
    vecs[4] = '{4'b1000, {16'h00FF, 16'h0000, 16'h0000, 16'h0000}, 4'b1000, 3, 16'h00FF};
    vecs[5] = '{4'b0110, {16'hAAAA, 16'h5A5A, 16'h8001, 16'hFFFF}, 4'b0010, 1, 16'h8001};

    reset     = 1'b1;
    req       = 4'b0000;
    req_data  = 64'h0;
    forceBusy = 1'b0;
    stubMute  = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      txBytes.delete();
      applyStimulus(vecs[v].reqV, vecs[v].dataV);
      waitAck(seen, lat);
      checkOutput($sformatf("v%0d.ackSeen", v), 64'(seen), 64'h1);
      checkOutput($sformatf("v%0d.ackLat", v), 64'(lat), 64'h1);
      checkOutput($sformatf("v%0d.ack", v), 64'(ack), 64'(vecs[v].expAck));
      checkOutput($sformatf("v%0d.busy", v), 64'(busy), 64'h1);
      req = 4'b0000;
      waitDone(seen, extra);
      checkOutput($sformatf("v%0d.done", v), 64'(seen), 64'h1);
      checkOutput($sformatf("v%0d.busyAtDone", v), 64'(busy), 64'h0);
      checkMsg($sformatf("v%0d", v), vecs[v].expId, vecs[v].expPay);
    end

    doReset();
    applyStimulus(4'b1111, {16'h4D33, 16'h4C22, 16'h4B11, 16'h4A00});
    for (int m = 0; m < 5; m++) begin
      expAck = 4'b0001 << (m % 4);
      txBytes.delete();
      waitAck(seen, lat);
      checkOutput($sformatf("rr%0d.ackSeen", m), 64'(seen), 64'h1);
      checkOutput($sformatf("rr%0d.ack", m), 64'(ack), 64'(expAck));
      if (m == 4) req = 4'b0000;
      waitDone(seen, extra);
      checkOutput($sformatf("rr%0d.done", m), 64'(seen), 64'h1);
      checkOutput($sformatf("rr%0d.extraAcks", m), 64'(extra), 64'h0);
      checkMsg($sformatf("rr%0d", m), m % 4, 16'h4A00 + 16'(((m % 4) * 16'h0111)));
    end

    doReset();
    forceBusy = 1'b1;
    applyStimulus(4'b0001, {48'h0, 16'hBEEF});
    waitAck(seen, lat);
    checkOutput("hold.ackSeen", 64'(seen), 64'h1);
    req = 4'b0000;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (start_tx) n++;
    end
    checkOutput("hold.noStart", 64'(n), 64'h0);
    forceBusy = 1'b0;
    @(negedge clk);
    checkOutput("hold.startAfterRelease", 64'(start_tx), 64'h1);
    waitDone(seen, extra);
    checkOutput("hold.done", 64'(seen), 64'h1);
    checkMsg("hold", 0, 16'hBEEF);

    doReset();
    stubMute = 1'b1;
    applyStimulus(4'b0010, {32'h0, 16'h1357, 16'h0});
    waitAck(seen, lat);
    checkOutput("tmo.ack", 64'(ack), 64'h2);
    req  = 4'b0000;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (start_tx) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("tmo.startSeen", 64'(seen), 64'h1);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n++;
      if (err) break;
    end
    checkOutput("tmo.errDelay", 64'(n), 64'd15);
    checkOutput("tmo.busyAtErr", 64'(busy), 64'h0);
    @(negedge clk);
    checkOutput("tmo.errPulse", 64'(err), 64'h0);
    checkOutput("tmo.noDone", 64'(done), 64'h0);
    stubMute = 1'b0;
    txBytes.delete();
    applyStimulus(4'b0001, {48'h0, 16'hC0DE});
    waitAck(seen, lat);
    checkOutput("tmoNext.ack", 64'(ack), 64'h1);
    req = 4'b0000;
    waitDone(seen, extra);
    checkOutput("tmoNext.done", 64'(seen), 64'h1);
    checkMsg("tmoNext", 0, 16'hC0DE);

    doReset();
    applyStimulus(4'b0100, {16'h0, 16'h2BAD, 32'h0});
    waitAck(seen, lat);
    checkOutput("rst.ack", 64'(ack), 64'h4);
    req = 4'b0000;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (start_tx) n++;
      if (n == 2) break;
    end
    checkOutput("rst.secondStart", 64'(n), 64'h2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkResetState("midReset");
    reset = 1'b0;
    repeat (4) @(negedge clk);
    txBytes.delete();
    applyStimulus(4'b1111, {16'h0, 16'h2BAD, 16'h0, 16'h600D});
    waitAck(seen, lat);
    checkOutput("rstNext.ack", 64'(ack), 64'h1);
    req = 4'b0000;
    waitDone(seen, extra);
    checkOutput("rstNext.done", 64'(seen), 64'h1);
    checkMsg("rstNext", 0, 16'h600D);

    doReset();
    applyStimulus(4'b0001, {48'h0, 16'hBEEF});
    waitAck(seen, lat);
    checkOutput("chg.ack", 64'(ack), 64'h1);
    req      = 4'b0000;
    req_data = {48'hFFFF_FFFF_FFFF, 16'h0000};
    waitDone(seen, extra);
    checkOutput("chg.done", 64'(seen), 64'h1);
    checkMsg("chg", 0, 16'hBEEF);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
